// File: rtl/axilite_master_arb_if.sv
// Bundle of requester-side and backend-side signals around the AXI-Lite master arbiter.
// The master modport is the arbiter's view; slave is seen by requesters and the backend.
interface axilite_master_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_write;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*32-1:0]     req_wdata;
   logic [NUM_REQ*4-1:0]      req_wstrb;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [31:0]               rsp_rdata;
   logic                      busy;
   logic [IDX_W-1:0]          grant_idx;
   logic                      bk_wstart;
   logic                      bk_rstart;
   logic [ADDR_W-1:0]         bk_waddr;
   logic [ADDR_W-1:0]         bk_raddr;
   logic [31:0]               bk_wdata;
   logic [3:0]                bk_wstrb;
   logic                      bk_wdone;
   logic                      bk_rdone;
   logic [31:0]               bk_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  bk_wdone, bk_rdone, bk_rdata,
      output req_ready, rsp_valid, rsp_rdata, busy, grant_idx,
      output bk_wstart, bk_rstart, bk_waddr, bk_raddr, bk_wdata, bk_wstrb
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output bk_wdone, bk_rdone, bk_rdata,
      input  req_ready, rsp_valid, rsp_rdata, busy, grant_idx,
      input  bk_wstart, bk_rstart, bk_waddr, bk_raddr, bk_wdata, bk_wstrb
   );
endinterface

// File: rtl/axilite_master_arb.sv
// Round-robin arbiter sharing one AXI-Lite master backend among NUM_REQ requesters,
// with at most one outstanding transaction (IDLE -> ISSUE -> WAIT -> RESP).
module axilite_master_arb #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32
) (
   input logic                  axi_aclk,
   input logic                  axi_aresetn,
   axilite_master_arb_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   grant_reg;
   logic [IDX_W-1:0]   last_grant_reg;
   logic [IDX_W-1:0]   winner;
   logic [IDX_W-1:0]   cand;
   logic               found;
   logic               cmd_write_reg;
   logic [ADDR_W-1:0]  waddr_reg;
   logic [ADDR_W-1:0]  raddr_reg;
   logic [31:0]        wdata_reg;
   logic [3:0]         wstrb_reg;
   logic [31:0]        rdata_reg;
   int                 idx;

   logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
   logic [31:0]        wdata_arr [NUM_REQ];
   logic [3:0]         wstrb_arr [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
         assign wdata_arr[gi] = bus.req_wdata[gi*32 +: 32];
         assign wstrb_arr[gi] = bus.req_wstrb[gi*4 +: 4];
      end
   endgenerate

   // Scan starts one past the last winner so a just-served requester goes to the back.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(last_grant_reg) + k) % NUM_REQ;
         cand = IDX_W'(idx);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_next    = state_reg;
      bus.req_ready = '0;
      bus.rsp_valid = '0;
      bus.rsp_rdata = '0;
      bus.bk_wstart = 1'b0;
      bus.bk_rstart = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (found) state_next = ISSUE;
         end
         ISSUE: begin
            bus.req_ready[grant_reg] = 1'b1;
            bus.bk_wstart = cmd_write_reg;
            bus.bk_rstart = !cmd_write_reg;
            state_next    = WAIT;
         end
         WAIT: begin
            // Only the done pulse matching the issued direction completes the transfer.
            if (cmd_write_reg ? bus.bk_wdone : bus.bk_rdone) state_next = RESP;
         end
         RESP: begin
            bus.rsp_valid[grant_reg] = 1'b1;
            bus.rsp_rdata = rdata_reg;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= IDX_W'(NUM_REQ - 1);
         cmd_write_reg  <= 1'b0;
         waddr_reg      <= '0;
         raddr_reg      <= '0;
         wdata_reg      <= '0;
         wstrb_reg      <= '0;
         rdata_reg      <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && found) begin
            grant_reg      <= winner;
            last_grant_reg <= winner;
            cmd_write_reg  <= bus.req_write[winner];
            rdata_reg      <= '0;
            if (bus.req_write[winner]) begin
               waddr_reg <= addr_arr[winner];
               wdata_reg <= wdata_arr[winner];
               wstrb_reg <= wstrb_arr[winner];
            end else begin
               raddr_reg <= addr_arr[winner];
            end
         end
         if (state_reg == WAIT && !cmd_write_reg && bus.bk_rdone) begin
            rdata_reg <= bus.bk_rdata;
         end
      end
   end

   assign bus.busy      = (state_reg != IDLE);
   assign bus.grant_idx = grant_reg;
   assign bus.bk_waddr  = waddr_reg;
   assign bus.bk_raddr  = raddr_reg;
   assign bus.bk_wdata  = wdata_reg;
   assign bus.bk_wstrb  = wstrb_reg;
endmodule

// File: tb/tb_axilite_master_arb.sv
// Directed bench for axilite_master_arb: transaction-level reference model checked every
// cycle, a latency-programmable backend responder, and literal expectations per scenario.
module tb_axilite_master_arb;
   localparam int N  = 4;
   localparam int AW = 32;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   axilite_master_arb_if #(.NUM_REQ(N), .ADDR_W(AW)) bus ();

   axilite_master_arb #(.NUM_REQ(N), .ADDR_W(AW)) dut (
      .axi_aclk   (clk),
      .axi_aresetn(rstn),
      .bus        (bus.master)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int grant_log[$];
   int rsp_log[$];
   int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: one transaction at a time; m_age counts cycles since the grant edge
   // (1 = start-pulse cycle), the response follows the cycle in which the matching done lands.
   bit          m_active = 0;
   bit          m_done   = 0;
   bit          m_write  = 0;
   int          m_who    = 0;
   int          m_age    = 0;
   int          m_done_age = 0;
   int          m_last   = N - 1;
   int          m_grant  = 0;
   int          mc;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   logic [31:0] m_rdata = '0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_active = 0;
         m_done   = 0;
         m_age    = 0;
         m_last   = N - 1;
         m_grant  = 0;
      end else if (!m_active) begin
         for (int k = 1; k <= N; k++) begin
            mc = (m_last + k) % N;
            if (bus.req_valid[mc]) begin
               m_active = 1;
               m_done   = 0;
               m_age    = 1;
               m_who    = mc;
               m_last   = mc;
               m_grant  = mc;
               m_write  = bus.req_write[mc];
               m_addr   = bus.req_addr[mc*AW +: AW];
               m_wdata  = bus.req_wdata[mc*32 +: 32];
               m_wstrb  = bus.req_wstrb[mc*4 +: 4];
               break;
            end
         end
      end else if (m_done && m_age == m_done_age + 1) begin
         m_active = 0;
      end else begin
         if (!m_done && m_age >= 2 && (m_write ? bus.bk_wdone : bus.bk_rdone)) begin
            m_done     = 1;
            m_done_age = m_age;
            m_rdata    = m_write ? 32'h0 : bus.bk_rdata;
         end
         m_age++;
      end
   end

   always @(negedge clk) begin : p_cmp
      bit             issue, resp;
      logic [N-1:0]   er, ev;
      issue = m_active && m_age == 1;
      resp  = m_active && m_done && m_age == m_done_age + 1;
      er = '0;
      ev = '0;
      if (issue) er[m_who] = 1'b1;
      if (resp)  ev[m_who] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      chk("rsp_valid", bus.rsp_valid, ev);
      chk("busy", bus.busy, m_active);
      chk("grant_idx", bus.grant_idx, m_grant);
      chk("bk_wstart", bus.bk_wstart, issue && m_write);
      chk("bk_rstart", bus.bk_rstart, issue && !m_write);
      if (issue && m_write) begin
         chk("bk_waddr", bus.bk_waddr, m_addr);
         chk("bk_wdata", bus.bk_wdata, m_wdata);
         chk("bk_wstrb", bus.bk_wstrb, m_wstrb);
      end
      if (issue && !m_write) chk("bk_raddr", bus.bk_raddr, m_addr);
      if (resp) chk("rsp_rdata", bus.rsp_rdata, m_rdata);
      for (int i = 0; i < N; i++) begin
         if (bus.req_ready[i]) grant_log.push_back(i);
         if (bus.rsp_valid[i]) rsp_log.push_back(i);
      end
   end

   // Backend responder: be_lat extra WAIT cycles before done; be_spur injects a wrong-type done.
   int          be_lat  = 0;
   bit          be_spur = 0;
   bit          be_w, be_ok;
   logic [31:0] be_a;

   initial begin
      bus.bk_wdone = 1'b0;
      bus.bk_rdone = 1'b0;
      bus.bk_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rstn && (bus.bk_wstart || bus.bk_rstart)) begin
            be_w  = bus.bk_wstart;
            be_a  = bus.bk_raddr;
            be_ok = 1;
            for (int i = 0; i < be_lat; i++) begin
               @(posedge clk); #1;
               bus.bk_rdone = 1'b0;
               if (!rstn) begin
                  be_ok = 0;
                  break;
               end
               if (i == 0 && be_spur && be_w) begin
                  bus.bk_rdone = 1'b1;
                  bus.bk_rdata = 32'hBAD0_BAD0;
               end
            end
            if (be_ok) begin
               @(posedge clk); #1;
               bus.bk_rdone = 1'b0;
               if (rstn) begin
                  if (be_w) bus.bk_wdone = 1'b1;
                  else begin
                     bus.bk_rdone = 1'b1;
                     bus.bk_rdata = be_a ^ 32'h2234_5658;
                  end
                  @(posedge clk); #1;
                  bus.bk_wdone = 1'b0;
                  bus.bk_rdone = 1'b0;
               end
            end
         end
      end
   end

   task automatic set_req(input int r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      bus.req_write[r]          = w;
      bus.req_addr[r*AW +: AW]  = a;
      bus.req_wdata[r*32 +: 32] = d;
      bus.req_wstrb[r*4 +: 4]   = s;
   endtask

   task automatic wait_ready(input int r, output int at);
      at = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (r < 0 ? (bus.req_ready != '0) : bus.req_ready[r]) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("ready_timeout", 0, 1);
   endtask

   task automatic wait_rsp(input int r, output int at);
      at = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.rsp_valid[r]) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk("rsp_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit seen;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("idle_timeout", 0, 1);
   endtask

   int t0, t1, base, n;

   initial begin
      bus.req_valid = '0;
      bus.req_write = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_grant_idx", bus.grant_idx, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_bk_waddr", bus.bk_waddr, 0);
      rstn = 1'b1;
      @(negedge clk);

      // Single write from requester 2, done 3 cycles after the start pulse.
      be_lat = 2;
      set_req(2, 1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
      bus.req_valid[2] = 1'b1;
      wait_ready(2, t0);
      chk("wr_bk_wstart", bus.bk_wstart, 1);
      chk("wr_bk_waddr", bus.bk_waddr, 32'h3000_0010);
      chk("wr_bk_wdata", bus.bk_wdata, 32'hDEAD_BEEF);
      chk("wr_bk_wstrb", bus.bk_wstrb, 4'hF);
      bus.req_valid[2] = 1'b0;
      wait_rsp(2, t1);
      chk("wr_turnaround", t1 - t0, 4);
      chk("wr_rsp_rdata", bus.rsp_rdata, 0);
      $display("txn write req=2 addr=0x30000010 ready_cyc=%0d rsp_cyc=%0d", t0, t1);

      // Single read from requester 0.
      be_lat = 1;
      set_req(0, 0, 32'h3000_0020, 32'h0, 4'h0);
      bus.req_valid[0] = 1'b1;
      wait_ready(0, t0);
      chk("rd_bk_rstart", bus.bk_rstart, 1);
      chk("rd_bk_raddr", bus.bk_raddr, 32'h3000_0020);
      bus.req_valid[0] = 1'b0;
      wait_rsp(0, t1);
      chk("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
      chk("rd_turnaround", t1 - t0, 3);
      $display("txn read req=0 rdata=0x%08h ready_cyc=%0d rsp_cyc=%0d", bus.rsp_rdata, t0, t1);

      // Zero-latency backend: done in the first WAIT cycle.
      be_lat = 0;
      set_req(3, 1, 32'h3000_0030, 32'h0BAD_F00D, 4'h3);
      bus.req_valid[3] = 1'b1;
      wait_ready(3, t0);
      bus.req_valid[3] = 1'b0;
      wait_rsp(3, t1);
      chk("zl_turnaround", t1 - t0, 2);
      $display("txn write req=3 zero-latency ready_cyc=%0d rsp_cyc=%0d", t0, t1);
      wait_idle();

      // Round robin with all requesters held valid.
      be_lat = 1;
      set_req(0, 0, 32'h3000_0100, 32'h0, 4'h0);
      set_req(1, 1, 32'h3000_0104, 32'h1111_1111, 4'hF);
      set_req(2, 0, 32'h3000_0108, 32'h0, 4'h0);
      set_req(3, 1, 32'h3000_010C, 32'h3333_3333, 4'hC);
      base = grant_log.size();
      t1   = rsp_log.size();
      n    = 0;
      bus.req_valid = 4'hF;
      for (int i = 0; i < 200 && n < 6; i++) begin
         @(negedge clk);
         if (bus.req_ready != '0) n++;
      end
      bus.req_valid = '0;
      chk("rr_six_grants", n, 6);
      wait_idle();
      for (int i = 0; i < 6; i++) begin
         chk("rr_grant_order", (base + i < grant_log.size()) ? grant_log[base + i] : -1, rr_exp[i]);
         $display("txn rr slot=%0d grant=%0d", i, (base + i < grant_log.size()) ? grant_log[base + i] : -1);
      end
      chk("rr_rsp_count", rsp_log.size() - t1, 6);

      // Serve req 3 with a spurious read-done mid-write, then wrap and skip to 1, 2.
      be_lat  = 2;
      be_spur = 1;
      set_req(3, 1, 32'h3000_0200, 32'hCAFE_0003, 4'hF);
      bus.req_valid[3] = 1'b1;
      wait_ready(3, t0);
      bus.req_valid[3] = 1'b0;
      wait_rsp(3, t1);
      be_spur = 0;
      chk("spur_turnaround", t1 - t0, 4);
      chk("spur_rsp_rdata", bus.rsp_rdata, 0);
      $display("txn write req=3 spurious-rdone ready_cyc=%0d rsp_cyc=%0d", t0, t1);
      wait_idle();
      be_lat = 0;
      base = grant_log.size();
      n    = 0;
      bus.req_valid = 4'b0110;
      for (int i = 0; i < 100 && n < 2; i++) begin
         @(negedge clk);
         if (bus.req_ready[1]) begin bus.req_valid[1] = 1'b0; n++; end
         if (bus.req_ready[2]) begin bus.req_valid[2] = 1'b0; n++; end
      end
      bus.req_valid = '0;
      wait_idle();
      chk("wrap_first", (base < grant_log.size()) ? grant_log[base] : -1, 1);
      chk("wrap_second", (base + 1 < grant_log.size()) ? grant_log[base + 1] : -1, 2);
      $display("txn wrap grants=%0d,%0d", (base < grant_log.size()) ? grant_log[base] : -1,
               (base + 1 < grant_log.size()) ? grant_log[base + 1] : -1);

      // Done pulses while idle must have no effect.
      @(negedge clk);
      bus.bk_wdone = 1'b1;
      bus.bk_rdone = 1'b1;
      @(negedge clk);
      bus.bk_wdone = 1'b0;
      bus.bk_rdone = 1'b0;
      @(negedge clk);
      chk("idle_done_busy", bus.busy, 0);
      chk("idle_done_rsp", bus.rsp_valid, 0);
      $display("txn idle spurious done pulses");

      // Asynchronous reset while waiting on a slow read.
      be_lat = 10;
      set_req(1, 0, 32'h3000_0300, 32'h0, 4'h0);
      bus.req_valid[1] = 1'b1;
      wait_ready(1, t0);
      bus.req_valid[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_pre_busy", bus.busy, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 0);
      chk("arst_req_ready", bus.req_ready, 0);
      chk("arst_rsp_valid", bus.rsp_valid, 0);
      chk("arst_grant_idx", bus.grant_idx, 0);
      chk("arst_bk_raddr", bus.bk_raddr, 0);
      chk("arst_bk_waddr", bus.bk_waddr, 0);
      chk("arst_starts", {bus.bk_wstart, bus.bk_rstart}, 0);
      chk("arst_rsp_rdata", bus.rsp_rdata, 0);
      repeat (2) @(negedge clk);
      rstn   = 1'b1;
      be_lat = 0;
      bus.req_valid = 4'hF;
      wait_ready(-1, t0);
      chk("post_rst_first_grant", bus.req_ready, 4'b0001);
      bus.req_valid = '0;
      $display("txn reset-in-wait then first grant onehot=0x%0h", bus.req_ready);
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
